pwm_capture: RTL and testbench

//   Receive-side counterpart to the PWM generator. Samples an asynchronous PWM

---
 rtl/pwm_capture.sv | 180 ++++++++++++++++++
 tb/tb_pwm_capture.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an async PWM input.
// Optional glitch filter on the synchronized input: PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
  parameter int CNT_W      = 16,
  parameter int FILTER_LEN = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             stuck_high,
  output logic             stuck_low
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_t;

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [1:0] sync_q;
  logic       pwm_s;
  logic       lvl;
  logic       rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], pwm_in};
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  // Window holds the newest sample plus FILTER_LEN-1 older ones.
  logic [FILTER_LEN-2:0] hist;
  logic [FILTER_LEN-1:0] win;
  logic                  filt_q;

  assign win = {hist, sync_q[1]};

  always_comb begin
    pwm_s = filt_q;
    if (&win) begin
      pwm_s = 1'b1;
    end else if (~|win) begin
      pwm_s = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist   <= '0;
      filt_q <= 1'b0;
    end else begin
      hist   <= win[FILTER_LEN-2:0];
      filt_q <= pwm_s;
    end
  end
`else
  logic unused_filt;

  assign unused_filt = |FILTER_LEN;
  assign pwm_s       = sync_q[1];
`endif

  // lvl and rise are aligned: rise marks the first high cycle of lvl.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lvl  <= 1'b0;
      rise <= 1'b0;
    end else begin
      lvl  <= pwm_s;
      rise <= pwm_s & ~lvl;
    end
  end

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] per_ctr;
  logic [CNT_W-1:0] per_d;
  logic [CNT_W-1:0] high_ctr;
  logic [CNT_W-1:0] high_d;
  logic [CNT_W-1:0] hc_d;
  logic [CNT_W-1:0] pc_d;
  logic             mv_d;
  logic             sh_d;
  logic             sl_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      per_ctr    <= '0;
      high_ctr   <= '0;
      high_cnt   <= '0;
      period_cnt <= '0;
      meas_valid <= 1'b0;
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
    end else begin
      state      <= state_d;
      per_ctr    <= per_d;
      high_ctr   <= high_d;
      high_cnt   <= hc_d;
      period_cnt <= pc_d;
      meas_valid <= mv_d;
      stuck_high <= sh_d;
      stuck_low  <= sl_d;
    end
  end

  always_comb begin
    state_d = state;
    per_d   = per_ctr;
    high_d  = high_ctr;
    hc_d    = high_cnt;
    pc_d    = period_cnt;
    mv_d    = 1'b0;
    sh_d    = stuck_high;
    sl_d    = stuck_low;
    if (!enable) begin
      state_d = IDLE;
      per_d   = '0;
      high_d  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_d = ARM;
          per_d   = '0;
          high_d  = '0;
        end
        ARM: begin
          if (rise) begin
            state_d = MEASURE;
            per_d   = ONE;
            high_d  = ONE;
            sh_d    = 1'b0;
            sl_d    = 1'b0;
          end
        end
        MEASURE: begin
          if (rise) begin
            pc_d   = per_ctr;
            hc_d   = high_ctr;
            mv_d   = 1'b1;
            sh_d   = 1'b0;
            sl_d   = 1'b0;
            per_d  = ONE;
            high_d = ONE;
          end else if (per_ctr == MAX) begin
            // No edge in the whole counter range: report a static input.
            state_d = ARM;
            mv_d    = 1'b1;
            pc_d    = MAX;
            hc_d    = lvl ? MAX : '0;
            sh_d    = lvl;
            sl_d    = ~lvl;
            per_d   = '0;
            high_d  = '0;
          end else begin
            per_d = per_ctr + ONE;
            if (lvl && high_ctr != MAX) begin
              high_d = high_ctr + ONE;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: random and directed stimulus against a period-level
// model of the capture block, plus fixed expectations for known waveforms.
module tb_pwm_capture;

  localparam int CNT_W = 10;
  localparam int MAXV  = (1 << CNT_W) - 1;
  localparam int FL    = 3;

  localparam int M_GEN    = 0;
  localparam int M_LO     = 1;
  localparam int M_HI     = 2;
  localparam int M_GLITCH = 3;
  localparam int M_RAND   = 4;

  logic             clk     = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable  = 1'b0;
  logic             pwm_in  = 1'b0;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             meas_valid;
  logic             stuck_high;
  logic             stuck_low;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  pwm_capture #(
    .CNT_W(CNT_W),
    .FILTER_LEN(FL)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .pwm_in(pwm_in),
    .high_cnt(high_cnt),
    .period_cnt(period_cnt),
    .meas_valid(meas_valid),
    .stuck_high(stuck_high),
    .stuck_low(stuck_low)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Stimulus source: 8-bit PWM generator (duty latched per period)
  // and a few alternative waveforms.
  int   mode   = M_GEN;
  int   duty   = 64;
  int   duty_l = 64;
  int   gcnt   = 0;
  int   run    = 0;
  logic rlvl   = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (gcnt == 0) duty_l = duty;
      case (mode)
        M_GEN:    pwm_in = (gcnt < duty_l);
        M_LO:     pwm_in = 1'b0;
        M_HI:     pwm_in = 1'b1;
        M_GLITCH: pwm_in = (gcnt < duty_l) ||
                           gcnt == 150 || gcnt == 151;
        default: begin
          if (run == 0) begin
            rlvl = ~rlvl;
            run  = $urandom_range(1, 40);
          end
          run--;
          pwm_in = rlvl;
        end
      endcase
      gcnt = (gcnt + 1) % 256;
    end
  end

  // Model: pin samples pq (newest first), g1..g3 the conditioned
  // level seen by the measurement 1..3 cycles back.
  int pq[$];
  int g1, g2, g3;
  int md;
  int t0;
  int ones;
  int m_hc, m_pc, m_mv, m_sh, m_sl;

  task automatic model_reset();
    pq.delete();
    for (int i = 0; i < FL; i++) pq.push_back(0);
    g1 = 0; g2 = 0; g3 = 0;
    md = 0; t0 = 0; ones = 0;
    m_hc = 0; m_pc = 0; m_mv = 0; m_sh = 0; m_sl = 0;
  endtask

  task automatic model_step(input int p, input int en);
    int v, r, g, el;
    bit eq;
    v = g2;
    r = (g2 == 1 && g3 == 0) ? 1 : 0;
`ifdef PWM_CAPTURE_FILTER_EN
    eq = 1'b1;
    for (int i = 1; i < FL; i++) if (pq[i] != pq[0]) eq = 1'b0;
    g = eq ? pq[0] : g1;
`else
    eq = 1'b1;
    g = eq ? pq[0] : g1;
`endif
    m_mv = 0;
    if (en == 0) begin
      md = 0;
    end else if (md == 0) begin
      md = 1;
    end else if (md == 1) begin
      if (r == 1) begin
        md = 2; t0 = cyc; ones = 1;
        m_sh = 0; m_sl = 0;
      end
    end else begin
      el = cyc - t0;
      if (r == 1) begin
        m_pc = el; m_hc = ones; m_mv = 1;
        m_sh = 0; m_sl = 0;
        t0 = cyc; ones = 1;
      end else if (el == MAXV) begin
        m_mv = 1; m_pc = MAXV;
        m_hc = v ? MAXV : 0;
        m_sh = v; m_sl = v ? 0 : 1;
        md = 1;
      end else begin
        ones += v;
      end
    end
    g3 = g2; g2 = g1; g1 = g;
    pq.push_front(p);
    void'(pq.pop_back());
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset_n) model_reset();
      else model_step(int'(pwm_in), int'(enable));
      #1;
      chk("high_cnt", int'(high_cnt), m_hc);
      chk("period_cnt", int'(period_cnt), m_pc);
      chk("meas_valid", int'(meas_valid), m_mv);
      chk("stuck_high", int'(stuck_high), m_sh);
      chk("stuck_low", int'(stuck_low), m_sl);
    end
  end

  task automatic wait_valid(input int lim, input string name,
                            output int at);
    bit ok;
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(posedge clk);
      #1;
      if (meas_valid) begin
        ok = 1'b1;
        at = cyc;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: no meas_valid within %0d cycles", name, lim);
    end
  endtask

  task automatic expect_hp(input string name, input int h, input int p);
    chk({name, "_high"}, int'(high_cnt), h);
    chk({name, "_period"}, int'(period_cnt), p);
  endtask

  initial begin
    int c0, c1, c2;
    repeat (3) @(negedge clk);
    chk("rst_high", int'(high_cnt), 0);
    chk("rst_period", int'(period_cnt), 0);
    chk("rst_valid", int'(meas_valid), 0);
    chk("rst_sh", int'(stuck_high), 0);
    chk("rst_sl", int'(stuck_low), 0);
    reset_n = 1'b1;
    enable  = 1'b1;

    wait_valid(700, "d64_first", c0);
    wait_valid(300, "d64_a", c1);
    expect_hp("d64_a", 64, 256);
    wait_valid(300, "d64_b", c2);
    expect_hp("d64_b", 64, 256);
    chk("d64_spacing", c2 - c1, 256);

    @(negedge clk);
    duty = 200;
    wait_valid(300, "d200_old", c0);
    expect_hp("d200_old", 64, 256);
    wait_valid(300, "d200_new", c1);
    expect_hp("d200_new", 200, 256);
    chk("d200_spacing", c1 - c0, 256);

    @(negedge clk);
    mode = M_LO;
    wait_valid(1100, "stuck_lo", c0);
    expect_hp("stuck_lo", 0, MAXV);
    chk("stuck_lo_flag", int'(stuck_low), 1);
    chk("stuck_lo_sh", int'(stuck_high), 0);

    @(negedge clk);
    duty = 255;
    mode = M_GEN;
    for (int i = 0; i < 600 && stuck_low; i++) @(negedge clk);
    chk("stuck_lo_clear", int'(stuck_low), 0);
    wait_valid(300, "d255_a", c0);
    wait_valid(300, "d255_b", c1);
    expect_hp("d255_b", 255, 256);

    @(negedge clk);
    mode = M_HI;
    wait_valid(1100, "stuck_hi", c0);
    expect_hp("stuck_hi", MAXV, MAXV);
    chk("stuck_hi_flag", int'(stuck_high), 1);

    @(negedge clk);
    duty = 64;
    mode = M_GEN;
    wait_valid(700, "pre_rst", c0);
    repeat (100) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_high", int'(high_cnt), 0);
    chk("midrst_period", int'(period_cnt), 0);
    chk("midrst_sh", int'(stuck_high), 0);
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    enable  = 1'b0;
    repeat (4) @(negedge clk);
    enable = 1'b1;
    wait_valid(700, "rearm_first", c0);
    wait_valid(300, "rearm_second", c1);
    expect_hp("rearm_second", 64, 256);

    @(negedge clk);
    mode = M_GLITCH;
    wait_valid(300, "glitch_a", c0);
`ifdef PWM_CAPTURE_FILTER_EN
    expect_hp("glitch_a", 64, 256);
    wait_valid(300, "glitch_b", c1);
    expect_hp("glitch_b", 64, 256);
`else
    expect_hp("glitch_a", 64, 150);
    wait_valid(300, "glitch_b", c1);
    expect_hp("glitch_b", 2, 106);
`endif

    for (int it = 0; it < 30; it++) begin
      int sel, len;
      @(negedge clk);
      sel = $urandom_range(0, 3);
      len = 600;
      case (sel)
        0: mode = M_RAND;
        1: begin
          mode = M_GEN;
          duty = $urandom_range(0, 255);
        end
        2: begin
          mode = M_LO;
          len  = 1200;
        end
        default: begin
          mode = M_HI;
          len  = 1200;
        end
      endcase
      for (int j = 0; j < len; j++) begin
        @(negedge clk);
        enable = ($urandom_range(0, 499) != 0);
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
